// File: rtl/argmax_reader.sv
// Scans the first N_OUT entries of a registered-read output RAM and reports the index and
// value of the largest entry. Ties resolve to the lowest index. Results are published on the
// single-cycle done pulse and held until the next completed scan.
module argmax_reader #(
  parameter int unsigned D_WIDTH = 4,
  parameter int unsigned A_WIDTH = 4,
  parameter int unsigned N_OUT   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_data,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] max_idx,
  output logic [D_WIDTH-1:0] max_val
);

  // One spare bit keeps N_OUT = 2**A_WIDTH from wrapping the counter.
  localparam logic [A_WIDTH:0] LastAddr = (A_WIDTH + 1)'(N_OUT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH:0]     addr_q, addr_d;
  logic                 pipe_vld_q;
  logic [A_WIDTH-1:0]   pipe_idx_q;
  logic [D_WIDTH-1:0]   run_max_q, run_max_d;
  logic [A_WIDTH-1:0]   run_idx_q, run_idx_d;
  logic [A_WIDTH-1:0]   max_idx_q;
  logic [D_WIDTH-1:0]   max_val_q;
  logic                 take;

  // Next state and address counter; the counter idles at 0 so r_addr needs no output mux.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRead;
      end
      StRead: begin
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Running compare on the data returned for the address issued one cycle earlier.
  always_comb begin
    take      = pipe_vld_q && ((pipe_idx_q == '0) || (ram_data > run_max_q));
    run_max_d = take ? ram_data   : run_max_q;
    run_idx_d = take ? pipe_idx_q : run_idx_q;
  end

  // State, read pipeline, running max and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      run_max_q  <= '0;
      run_idx_q  <= '0;
      max_idx_q  <= '0;
      max_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pipe_vld_q <= (state_q == StRead);
      pipe_idx_q <= addr_q[A_WIDTH-1:0];
      if (pipe_vld_q) begin
        run_max_q <= run_max_d;
        run_idx_q <= run_idx_d;
      end
      // The last entry arrives during DRAIN, so fold it in while publishing.
      if (state_q == StDrain) begin
        max_val_q <= run_max_d;
        max_idx_q <= run_idx_d;
      end
    end
  end

  assign r_addr  = addr_q[A_WIDTH-1:0];
  assign busy    = (state_q == StRead) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign max_idx = max_idx_q;
  assign max_val = max_val_q;

endmodule
